// File: rtl/frame_rx_pkg.sv
// Shared types and constants for the serial frame receiver: FSM states,
// CRC-16/CCITT-FALSE constants, header byte positions and a bytewise CRC step.
package frame_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEAD,
        ST_BODY,
        ST_CRC,
        ST_DONE
    } state_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // Header byte positions, sized for the 17-bit index arithmetic.
    localparam logic [16:0] IDX_INFO   = 17'd0;
    localparam logic [16:0] IDX_SEG    = 17'd1;
    localparam logic [16:0] IDX_LEN_HI = 17'd2;
    localparam logic [16:0] IDX_LEN_LO = 17'd3;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ({c[14:0], 1'b0} ^ CRC_POLY) : {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/frame_crc16.sv
// Byte-wide CRC-16/CCITT-FALSE engine: synchronous clear to the init value,
// one byte folded in per enabled cycle.
module frame_crc16
    import frame_rx_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [7:0]  i_data,
    output logic [15:0] o_crc
);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_crc <= CRC_INIT;
        end else if (i_clr) begin
            o_crc <= CRC_INIT;
        end else if (i_en) begin
            o_crc <= crc16_byte(o_crc, i_data);
        end
    end

endmodule

// File: rtl/frame_rx_parser.sv
// Serial frame receiver: assembles bytes, tracks header/body/CRC, emits payload
// bytes and result pulses. Define FRAME_RX_STATS_EN to build the ok/err counters.
module frame_rx_parser
    import frame_rx_pkg::*;
#(
    parameter int MAX_LEN   = 1024,
    parameter int HDR_LEN   = 21,
    parameter int PTYPE_IDX = 21,
    parameter int LSB_FIRST = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_data_en,
    input  logic        i_bit_vld,
    input  logic        i_data_in,
    output logic [7:0]  o_byte_data,
    output logic        o_byte_valid,
    output logic        o_sof,
    output logic        o_eof,
    output logic        o_crc_ok,
    output logic        o_crc_err,
    output logic        o_len_err,
    output logic [7:0]  o_info_type,
    output logic [7:0]  o_para_type,
    output logic [15:0] o_frame_len,
    output logic [15:0] o_ok_cnt,
    output logic [15:0] o_err_cnt
);

    localparam int CW = $clog2(MAX_LEN) + 1;

    state_t        state, state_nxt;
    logic          en_d, en_rise, active, aborting;
    logic          bit_take, byte_done, len_bad, crc_clr, crc_en;
    logic [2:0]    bit_cnt;
    logic [CW-1:0] byte_cnt;
    logic [7:0]    sh, nxt_byte, len_hi, rx_crc_hi;
    logic [16:0]   idx17, len17, last_body, last_idx;
    logic [15:0]   crc;

    assign active    = state inside {ST_HEAD, ST_BODY, ST_CRC};
    assign en_rise   = i_data_en & ~en_d;
    assign aborting  = active & ~i_data_en;
    assign bit_take  = active & i_data_en & i_bit_vld;
    assign byte_done = bit_take & (bit_cnt == 3'd7);
    assign nxt_byte  = (LSB_FIRST != 0) ? {i_data_in, sh[7:1]} : {sh[6:0], i_data_in};
    assign idx17     = 17'(byte_cnt);
    assign len17     = {1'b0, len_hi, nxt_byte};
    assign len_bad   = ((len17 + 17'd4) < 17'(HDR_LEN)) || ((len17 + 17'd6) > 17'(MAX_LEN));
    assign crc_clr   = (state == ST_IDLE) & en_rise;
    assign crc_en    = byte_done & (state inside {ST_HEAD, ST_BODY});

    frame_crc16 u_crc (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (crc_clr),
        .i_en    (crc_en),
        .i_data  (nxt_byte),
        .o_crc   (crc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (en_rise) state_nxt = ST_HEAD;
            ST_HEAD: begin
                if (!i_data_en)
                    state_nxt = ST_IDLE;
                else if (byte_done && idx17 == IDX_LEN_LO)
                    state_nxt = len_bad ? ST_DONE : ((len17 == 17'd0) ? ST_CRC : ST_BODY);
            end
            ST_BODY: begin
                if (!i_data_en)                             state_nxt = ST_IDLE;
                else if (byte_done && idx17 == last_body)   state_nxt = ST_CRC;
            end
            ST_CRC: begin
                if (!i_data_en)                             state_nxt = ST_IDLE;
                else if (byte_done && idx17 == last_idx)    state_nxt = ST_DONE;
            end
            ST_DONE: if (!i_data_en) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // en_d resets high so a gate held high across reset is not a new frame
            en_d         <= 1'b1;
            bit_cnt      <= '0;
            byte_cnt     <= '0;
            sh           <= '0;
            len_hi       <= '0;
            rx_crc_hi    <= '0;
            last_body    <= '0;
            last_idx     <= '0;
            o_byte_data  <= '0;
            o_byte_valid <= 1'b0;
            o_sof        <= 1'b0;
            o_eof        <= 1'b0;
            o_crc_ok     <= 1'b0;
            o_crc_err    <= 1'b0;
            o_len_err    <= 1'b0;
            o_info_type  <= '0;
            o_para_type  <= '0;
            o_frame_len  <= '0;
        end else begin
            en_d         <= i_data_en;
            o_byte_valid <= 1'b0;
            o_sof        <= 1'b0;
            o_eof        <= 1'b0;
            o_crc_ok     <= 1'b0;
            o_crc_err    <= 1'b0;
            o_len_err    <= aborting;

            if (crc_clr) begin
                bit_cnt  <= '0;
                byte_cnt <= '0;
                sh       <= '0;
            end else if (bit_take) begin
                bit_cnt <= bit_cnt + 3'd1;
                sh      <= nxt_byte;
                if (byte_done) byte_cnt <= byte_cnt + CW'(1);
            end

            if (byte_done) begin
                case (state)
                    ST_HEAD: begin
                        if (idx17 == IDX_INFO)   o_info_type <= nxt_byte;
                        if (idx17 == IDX_LEN_HI) len_hi      <= nxt_byte;
                        if (idx17 == IDX_LEN_LO) begin
                            o_frame_len <= len17[15:0];
                            last_body   <= len17 + 17'd3;
                            last_idx    <= len17 + 17'd5;
                            o_len_err   <= len_bad;
                        end
                    end
                    ST_BODY: begin
                        if (idx17 >= 17'(HDR_LEN)) begin
                            o_byte_valid <= 1'b1;
                            o_byte_data  <= nxt_byte;
                            o_sof        <= (idx17 == 17'(HDR_LEN));
                            o_eof        <= (idx17 == last_body);
                        end
                    end
                    ST_CRC: begin
                        if (idx17 == last_idx) begin
                            o_crc_ok  <= ({rx_crc_hi, nxt_byte} == crc);
                            o_crc_err <= ({rx_crc_hi, nxt_byte} != crc);
                        end else begin
                            rx_crc_hi <= nxt_byte;
                        end
                    end
                    default: ;
                endcase
                if (idx17 == 17'(PTYPE_IDX)) o_para_type <= nxt_byte;
            end
        end
    end

`ifdef FRAME_RX_STATS_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ok_cnt  <= '0;
            o_err_cnt <= '0;
        end else begin
            if (o_crc_ok && o_ok_cnt != 16'hFFFF)
                o_ok_cnt <= o_ok_cnt + 16'd1;
            if ((o_crc_err || o_len_err) && o_err_cnt != 16'hFFFF)
                o_err_cnt <= o_err_cnt + 16'd1;
        end
    end
`else
    assign o_ok_cnt  = '0;
    assign o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_frame_rx_parser.sv
// Bench for frame_rx_parser: table of frames with a payload scoreboard, plus
// hand sequences for bit order, truncation in the header and reset mid-body.
module tb_frame_rx_parser;

    logic i_clk = 1'b0, i_rst_n = 1'b0, i_data_en = 1'b0, i_bit_vld = 1'b0, i_data_in = 1'b0;
    always #5 i_clk = ~i_clk;

    logic [7:0]  o_byte_data, o_info_type, o_para_type;
    logic        o_byte_valid, o_sof, o_eof, o_crc_ok, o_crc_err, o_len_err;
    logic [15:0] o_frame_len, o_ok_cnt, o_err_cnt;
    logic [7:0]  l_byte_data, l_info_type, l_para_type;
    logic        l_byte_valid, l_sof, l_eof, l_crc_ok, l_crc_err, l_len_err;
    logic [15:0] l_frame_len, l_ok_cnt, l_err_cnt;

    frame_rx_parser dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data_en(i_data_en), .i_bit_vld(i_bit_vld),
        .i_data_in(i_data_in), .o_byte_data(o_byte_data), .o_byte_valid(o_byte_valid),
        .o_sof(o_sof), .o_eof(o_eof), .o_crc_ok(o_crc_ok), .o_crc_err(o_crc_err),
        .o_len_err(o_len_err), .o_info_type(o_info_type), .o_para_type(o_para_type),
        .o_frame_len(o_frame_len), .o_ok_cnt(o_ok_cnt), .o_err_cnt(o_err_cnt)
    );

    frame_rx_parser #(.LSB_FIRST(1)) dut_lsb (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data_en(i_data_en), .i_bit_vld(i_bit_vld),
        .i_data_in(i_data_in), .o_byte_data(l_byte_data), .o_byte_valid(l_byte_valid),
        .o_sof(l_sof), .o_eof(l_eof), .o_crc_ok(l_crc_ok), .o_crc_err(l_crc_err),
        .o_len_err(l_len_err), .o_info_type(l_info_type), .o_para_type(l_para_type),
        .o_frame_len(l_frame_len), .o_ok_cnt(l_ok_cnt), .o_err_cnt(l_err_cnt)
    );

`ifdef FRAME_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam int HDR = 21;

    typedef struct {
        int len;
        int nsend;
        bit flip;
        bit ok;
        bit cerr;
        bit lerr;
        int npay;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        bit         sof;
        bit         eof;
    } pay_t;

    int         checks = 0, failures = 0;
    int         n_ok = 0, n_cerr = 0, n_lerr = 0, n_bv = 0;
    logic [7:0] fb[$];
    pay_t       sb[$];

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endfunction

    task automatic sample();
        pay_t e;
        n_ok   += int'(o_crc_ok);
        n_cerr += int'(o_crc_err);
        n_lerr += int'(o_len_err);
        if (o_byte_valid) begin
            n_bv++;
            if (sb.size() == 0) begin
                chk("byte_extra", int'(o_byte_data), -1);
            end else begin
                e = sb.pop_front();
                chk("pay_data", int'(o_byte_data), int'(e.d));
                chk("pay_sof", int'(o_sof), int'(e.sof));
                chk("pay_eof", int'(o_eof), int'(e.eof));
            end
        end
    endtask

    task automatic step(input logic en, input logic vld, input logic d);
        @(posedge i_clk);
        #1;
        sample();
        i_data_en = en;
        i_bit_vld = vld;
        i_data_in = d;
    endtask

    function automatic logic [7:0] gen(input int vi, input int i, input int len);
        logic [15:0] l16;
        l16 = 16'(len);
        if (i == 0) return 8'(8'h40 + vi);
        if (i == 1) return 8'h03;
        if (i == 2) return l16[15:8];
        if (i == 3) return l16[7:0];
        if (vi == 0 && i == 21) return 8'hA5;
        if (vi == 0 && i == 22) return 8'h5A;
        if (vi == 0 && i == 23) return 8'h3C;
        return 8'(i * 37 + vi * 11 + 5);
    endfunction

    // Serial LFSR form of CRC-16/CCITT-FALSE over fb[0..n-1]
    function automatic logic [15:0] crc_ref(input int n);
        logic [15:0] c;
        logic        f;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 7; b >= 0; b--) begin
                f = c[15] ^ fb[i][b];
                c = {c[14:0], 1'b0};
                if (f) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    task automatic build(input int vi, input int len, input bit flip);
        logic [15:0] c;
        fb.delete();
        for (int i = 0; i < len + 4; i++) fb.push_back(gen(vi, i, len));
        c = crc_ref(len + 4);
        fb.push_back(c[15:8]);
        fb.push_back(c[7:0] ^ {7'd0, flip});
    endtask

    task automatic send_bytes(input int from, input int to, input bit push, input int len);
        pay_t p;
        for (int i = from; i < to; i++) begin
            for (int b = 7; b >= 0; b--) begin
                if (push && b == 7 && i >= HDR && i <= len + 3) begin
                    p.d = fb[i]; p.sof = (i == HDR); p.eof = (i == len + 3);
                    sb.push_back(p);
                end
                if ($urandom_range(0, 3) == 0) step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
                step(1'b1, 1'b1, fb[i][b]);
            end
        end
    endtask

    task automatic run_frame(input int n, input bit push, input int len);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        send_bytes(0, n, push, len);
        repeat (4) step(1'b0, 1'b0, 1'b0);
    endtask

    vec_t vecs[10];

    initial begin
        int         s_ok, s_cerr, s_lerr, s_bv, n, vi;
        logic [7:0] exp_para;
        vec_t       v;

        vecs[0] = '{20,   -1, 1'b0, 1'b1, 1'b0, 1'b0, 3};
        vecs[1] = '{20,   -1, 1'b1, 1'b0, 1'b1, 1'b0, 3};
        vecs[2] = '{10,   -1, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[3] = '{1020,  8, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[4] = '{40,   16, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[5] = '{17,   -1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        vecs[6] = '{30,   -1, 1'b0, 1'b1, 1'b0, 1'b0, 13};
        vecs[7] = '{1018, -1, 1'b0, 1'b1, 1'b0, 1'b0, 1001};
        vecs[8] = '{1019,  8, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[9] = '{16,   -1, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        exp_para = 8'h00;

        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_main", int'(|{o_byte_data, o_byte_valid, o_sof, o_eof, o_crc_ok, o_crc_err,
            o_len_err, o_info_type, o_para_type, o_frame_len, o_ok_cnt, o_err_cnt}), 0);
        chk("rst_lsb", int'(|{l_byte_data, l_byte_valid, l_sof, l_eof, l_crc_ok, l_crc_err,
            l_len_err, l_info_type, l_para_type, l_frame_len, l_ok_cnt, l_err_cnt}), 0);
        i_rst_n = 1'b1;
        repeat (2) step(1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 10; k++) begin
            v  = vecs[k];
            vi = (k == 1) ? 0 : k;
            build(vi, v.len, v.flip);
            n = (v.nsend < 0) ? fb.size() : v.nsend;
            s_ok = n_ok; s_cerr = n_cerr; s_lerr = n_lerr; s_bv = n_bv;
            run_frame(n, v.npay > 0, v.len);
            if (!v.lerr) exp_para = fb[HDR];
            chk($sformatf("f%0d_crc_ok", k),  n_ok - s_ok, int'(v.ok));
            chk($sformatf("f%0d_crc_err", k), n_cerr - s_cerr, int'(v.cerr));
            chk($sformatf("f%0d_len_err", k), n_lerr - s_lerr, int'(v.lerr));
            chk($sformatf("f%0d_nbytes", k),  n_bv - s_bv, v.npay);
            chk($sformatf("f%0d_sb_left", k), sb.size(), 0);
            chk($sformatf("f%0d_info", k),    int'(o_info_type), int'(8'h40) + vi);
            chk($sformatf("f%0d_flen", k),    int'(o_frame_len), v.len);
            chk($sformatf("f%0d_para", k),    int'(o_para_type), int'(exp_para));
            sb.delete();
        end
        chk("stat_ok", int'(o_ok_cnt), STATS ? 4 : 0);
        chk("stat_err", int'(o_err_cnt), STATS ? 6 : 0);

        // Bit order: 1,0,0,0,0,0,0,0 then gate drops inside the header
        s_lerr = n_lerr; s_ok = n_ok; s_cerr = n_cerr;
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int b = 0; b < 8; b++) step(1'b1, 1'b1, (b == 0));
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk("msb_info", int'(o_info_type), 'h80);
        chk("lsb_info", int'(l_info_type), 'h01);
        chk("hdr_trunc_len_err", n_lerr - s_lerr, 1);
        chk("hdr_trunc_no_crc", (n_ok - s_ok) + (n_cerr - s_cerr), 0);
        chk("stat_err2", int'(o_err_cnt), STATS ? 7 : 0);

        // Reset mid-body, then a held-high gate must not start a frame
        build(6, 30, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        send_bytes(0, 10, 1'b0, 30);
        i_rst_n = 1'b0;
        #1;
        chk("midrst_main", int'(|{o_byte_data, o_byte_valid, o_sof, o_eof, o_crc_ok, o_crc_err,
            o_len_err, o_info_type, o_para_type, o_frame_len, o_ok_cnt, o_err_cnt}), 0);
        chk("midrst_lsb", int'(|{l_byte_data, l_byte_valid, l_sof, l_eof, l_crc_ok, l_crc_err,
            l_len_err, l_info_type, l_para_type, l_frame_len, l_ok_cnt, l_err_cnt}), 0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        i_rst_n = 1'b1;
        s_lerr = n_lerr; s_bv = n_bv; s_ok = n_ok; s_cerr = n_cerr;
        send_bytes(10, 36, 1'b0, 30);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk("postrst_no_bytes", n_bv - s_bv, 0);
        chk("postrst_no_pulses", (n_lerr - s_lerr) + (n_ok - s_ok) + (n_cerr - s_cerr), 0);
        chk("postrst_flen", int'(o_frame_len), 0);

        build(0, 20, 1'b0);
        s_ok = n_ok; s_bv = n_bv;
        run_frame(fb.size(), 1'b1, 20);
        chk("recover_ok", n_ok - s_ok, 1);
        chk("recover_nbytes", n_bv - s_bv, 3);
        chk("recover_sb_left", sb.size(), 0);
        chk("recover_stat_ok", int'(o_ok_cnt), STATS ? 1 : 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
